// File: rtl/common_pkg.sv
// Shared types for the memory port arbiter: FSM states, port owner and the
// request payload that is latched toward the unified memory.
package common_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_ISSUE = 2'd1,
      ARB_WAIT  = 2'd2
   } arb_state_t;

   typedef enum logic {
      OWNER_IF = 1'b0,
      OWNER_DM = 1'b1
   } arb_owner_t;

   typedef struct packed {
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
   } mem_req_t;

   localparam int STARVE_CNT_W = 4;

   // Fetch is read-only: full word enables, no write data.
   function automatic mem_req_t fetch_payload(input logic [31:0] addr);
      mem_req_t p;
      p.we    = 1'b0;
      p.be    = 4'hF;
      p.addr  = addr;
      p.wdata = 32'h0;
      return p;
   endfunction

   function automatic mem_req_t data_payload(input logic        we,
                                             input logic [3:0]  be,
                                             input logic [31:0] addr,
                                             input logic [31:0] wdata);
      mem_req_t p;
      p.we    = we;
      p.be    = be;
      p.addr  = addr;
      p.wdata = wdata;
      return p;
   endfunction

endpackage

// File: rtl/arb_perf_counter.sv
// 32-bit saturating event counter; counts one per clock while inc is high.
module arb_perf_counter (
   input  logic        clk,
   input  logic        rst,
   input  logic        inc,
   output logic [31:0] count
);

   logic [31:0] count_reg;
   logic [31:0] count_next;

   always_comb begin
      count_next = count_reg;
      if (inc && (count_reg != 32'hFFFF_FFFF)) begin
         count_next = count_reg + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_reg <= 32'h0;
      end else begin
         count_reg <= count_next;
      end
   end

   assign count = count_reg;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between fetch (read-only) and the memory stage.
// Define MEM_ARB_PERF_EN to build the perf_if_wait / perf_dm_wait counters.
module mem_port_arbiter
   import common_pkg::*;
#(
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_gnt,
   output logic        if_rvalid,
   output logic [31:0] if_rdata,
   input  logic        dm_req,
   input  logic        dm_we,
   input  logic [3:0]  dm_be,
   input  logic [31:0] dm_addr,
   input  logic [31:0] dm_wdata,
   output logic        dm_gnt,
   output logic        dm_rvalid,
   output logic [31:0] dm_rdata,
   output logic        mem_req,
   output logic        mem_we,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_ready,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata,
   output logic        busy,
   output logic [31:0] perf_if_wait,
   output logic [31:0] perf_dm_wait
);

   localparam logic [STARVE_CNT_W-1:0] STARVE_LIM = STARVE_CNT_W'(STARVE_MAX);

   arb_state_t                state_reg;
   arb_state_t                state_next;
   arb_owner_t                owner_reg;
   logic [STARVE_CNT_W-1:0]   starve_cnt_reg;
   logic [STARVE_CNT_W-1:0]   starve_cnt_next;
   mem_req_t                  payload_reg;
   logic                      mem_req_reg;
   logic                      if_gnt_reg;
   logic                      dm_gnt_reg;
   logic                      if_rvalid_reg;
   logic                      dm_rvalid_reg;
   logic [31:0]               if_rdata_reg;
   logic [31:0]               dm_rdata_reg;

   logic                      pick_if;
   logic                      grant_if;
   logic                      grant_dm;
   logic                      accept;
   logic                      respond;

   // Memory stage wins ties unless fetch has already waited STARVE_MAX dm grants.
   assign pick_if  = if_req && (!dm_req || (starve_cnt_reg == STARVE_LIM));
   assign grant_if = (state_reg == ARB_IDLE) && pick_if;
   assign grant_dm = (state_reg == ARB_IDLE) && dm_req && !pick_if;
   assign accept   = (state_reg == ARB_ISSUE) && mem_ready;
   assign respond  = (state_reg == ARB_WAIT) && mem_rvalid;

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ARB_IDLE: begin
            if (grant_if || grant_dm) begin
               state_next = ARB_ISSUE;
            end
         end
         ARB_ISSUE: begin
            if (accept) begin
               state_next = ARB_WAIT;
            end
         end
         ARB_WAIT: begin
            if (respond) begin
               state_next = ARB_IDLE;
            end
         end
         default: state_next = ARB_IDLE;
      endcase
   end

   always_comb begin
      starve_cnt_next = starve_cnt_reg;
      if (!if_req || grant_if) begin
         starve_cnt_next = '0;
      end else if (grant_dm && (starve_cnt_reg != STARVE_LIM)) begin
         starve_cnt_next = starve_cnt_reg + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg      <= ARB_IDLE;
         owner_reg      <= OWNER_IF;
         starve_cnt_reg <= '0;
         payload_reg    <= '0;
         mem_req_reg    <= 1'b0;
         if_gnt_reg     <= 1'b0;
         dm_gnt_reg     <= 1'b0;
      end else begin
         state_reg      <= state_next;
         starve_cnt_reg <= starve_cnt_next;
         if_gnt_reg     <= grant_if;
         dm_gnt_reg     <= grant_dm;
         if (grant_if) begin
            owner_reg   <= OWNER_IF;
            payload_reg <= fetch_payload(if_addr);
            mem_req_reg <= 1'b1;
         end else if (grant_dm) begin
            owner_reg   <= OWNER_DM;
            payload_reg <= data_payload(dm_we, dm_be, dm_addr, dm_wdata);
            mem_req_reg <= 1'b1;
         end else if (accept) begin
            mem_req_reg <= 1'b0;
         end
      end
   end

   // Response path: rdata registers keep their value between responses.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         if_rvalid_reg <= 1'b0;
         dm_rvalid_reg <= 1'b0;
         if_rdata_reg  <= 32'h0;
         dm_rdata_reg  <= 32'h0;
      end else begin
         if_rvalid_reg <= respond && (owner_reg == OWNER_IF);
         dm_rvalid_reg <= respond && (owner_reg == OWNER_DM);
         if (respond && (owner_reg == OWNER_IF)) begin
            if_rdata_reg <= mem_rdata;
         end
         if (respond && (owner_reg == OWNER_DM)) begin
            dm_rdata_reg <= payload_reg.we ? 32'h0 : mem_rdata;
         end
      end
   end

   assign if_gnt    = if_gnt_reg;
   assign dm_gnt    = dm_gnt_reg;
   assign if_rvalid = if_rvalid_reg;
   assign dm_rvalid = dm_rvalid_reg;
   assign if_rdata  = if_rdata_reg;
   assign dm_rdata  = dm_rdata_reg;
   assign mem_req   = mem_req_reg;
   assign mem_we    = payload_reg.we;
   assign mem_be    = payload_reg.be;
   assign mem_addr  = payload_reg.addr;
   assign mem_wdata = payload_reg.wdata;
   assign busy      = (state_reg != ARB_IDLE);

`ifdef MEM_ARB_PERF_EN
   // A requester is waiting in any cycle its req is up but its grant pulse is not.
   logic if_wait_evt;
   logic dm_wait_evt;

   assign if_wait_evt = if_req & ~if_gnt_reg;
   assign dm_wait_evt = dm_req & ~dm_gnt_reg;

   arb_perf_counter u_if_wait (
      .clk   (clk),
      .rst   (rst),
      .inc   (if_wait_evt),
      .count (perf_if_wait)
   );

   arb_perf_counter u_dm_wait (
      .clk   (clk),
      .rst   (rst),
      .inc   (dm_wait_evt),
      .count (perf_dm_wait)
   );
`else
   assign perf_if_wait = 32'h0;
   assign perf_dm_wait = 32'h0;
`endif

endmodule
